// File: rtl/mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_pkg
// Shared constants and types for the memory port arbiter.
//   MEM_DEPTH    : number of words the downstream memory implements
//   ERR_RDATA    : read data returned for a rejected out-of-range access
//   master_idx_t : index of a requesting master (up to 4 masters)
// ----------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int unsigned MEM_DEPTH = 256;
  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

  typedef logic [1:0] master_idx_t;

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin selector. The search starts at the master
// after last_i and wraps, so the most recently granted master has lowest
// priority.
// Ports:
//   req_i     in  N  request vector
//   last_i    in  2  index of the most recently granted master
//   sel_oh_o  out N  one-hot selected master (all zero when no request)
//   sel_idx_o out 2  index of the selected master (0 when no request)
//   valid_o   out 1  at least one request is present
// ----------------------------------------------------------------------------
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0] req_i,
  input  master_idx_t  last_i,
  output logic [N-1:0] sel_oh_o,
  output master_idx_t  sel_idx_o,
  output logic         valid_o
);

  always_comb begin
    // NOTE: every output gets a default before the search loop; without it a
    // path that skips the assignment would infer a latch.
    sel_oh_o  = '0;
    sel_idx_o = '0;
    valid_o   = 1'b0;
    // Outer loop walks priority distance, inner loop matches the master at
    // that distance; only constant indices are used on req_i.
    for (int d = 0; d < N; d++) begin
      for (int j = 0; j < N; j++) begin
        if (!valid_o && req_i[j] && (j == ((int'(last_i) + 1 + d) % N))) begin
          valid_o     = 1'b1;
          sel_idx_o   = master_idx_t'(j);
          sel_oh_o[j] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
// Merges NUM_MASTERS OBI-style req/gnt/rvalid ports onto one single-port
// memory with round-robin arbitration. Read data is combinational on the
// address at grant time, so it is captured then and returned to the owning
// master alongside the memory's registered rvalid.
//
// Optional feature (macro MEM_ARB_ADDR_CHECK_EN): addresses >= MEM_DEPTH are
// not forwarded; the arbiter grants locally and answers next cycle with
// ERR_RDATA, pulsing addr_err_o.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   m_req_i/m_gnt_o    per-master request / same-cycle grant
//   m_rvalid_o         per-master response valid
//   m_addr_i/m_we_i/m_wdata_i  per-master request payload (flattened)
//   m_rdata_o          shared response data, qualified by m_rvalid_o
//   mem_*              memory-side OBI port
//   addr_err_o         (MEM_ARB_ADDR_CHECK_EN only) out-of-range response
//   protocol_err_o     sticky: memory rvalid with no pending response
// ----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        m_req_i,
  output logic [NUM_MASTERS-1:0]        m_gnt_o,
  output logic [NUM_MASTERS-1:0]        m_rvalid_o,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr_i,
  input  logic [NUM_MASTERS-1:0]        m_we_i,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata_i,
  output logic [DATA_W-1:0]             m_rdata_o,
  output logic                          mem_req_o,
  input  logic                          mem_gnt_i,
  input  logic                          mem_rvalid_i,
  output logic [ADDR_W-1:0]             mem_addr_o,
  output logic                          mem_we_o,
  output logic [DATA_W-1:0]             mem_wdata_o,
  input  logic [DATA_W-1:0]             mem_rdata_i,
`ifdef MEM_ARB_ADDR_CHECK_EN
  output logic                          addr_err_o,
`endif
  output logic                          protocol_err_o
);

  master_idx_t              last_grant_q, last_grant_d;
  master_idx_t              owner_q, owner_d;
  logic                     pending_q, pending_d;
  logic [DATA_W-1:0]        rsp_data_q, rsp_data_d;
  logic                     post_rst_q;
  logic                     protocol_err_q, protocol_err_d;

  logic [NUM_MASTERS-1:0]   sel_oh;
  master_idx_t              sel_idx;
  logic                     any_req;
  logic [ADDR_W-1:0]        sel_addr;
  logic                     sel_we;
  logic [DATA_W-1:0]        sel_wdata;
  logic                     addr_bad;
  logic                     grant;
  logic                     rsp_fire;

  rr_arbiter #(
    .N (NUM_MASTERS)
  ) u_rr (
    .req_i     (m_req_i),
    .last_i    (last_grant_q),
    .sel_oh_o  (sel_oh),
    .sel_idx_o (sel_idx),
    .valid_o   (any_req)
  );

  assign sel_addr  = m_addr_i[int'(sel_idx)*ADDR_W +: ADDR_W];
  assign sel_we    = m_we_i[sel_idx];
  assign sel_wdata = m_wdata_i[int'(sel_idx)*DATA_W +: DATA_W];

`ifdef MEM_ARB_ADDR_CHECK_EN
  logic err_pending_q, err_pending_d;
  assign addr_bad = any_req && (sel_addr >= ADDR_W'(MEM_DEPTH));
`else
  assign addr_bad = 1'b0;
`endif

  // Payload is forced to zero while idle so the memory side is quiet.
  assign mem_req_o   = any_req & ~addr_bad;
  assign mem_addr_o  = any_req ? sel_addr  : '0;
  assign mem_we_o    = any_req & sel_we;
  assign mem_wdata_o = any_req ? sel_wdata : '0;

  // A rejected address is granted locally; otherwise the memory decides.
  assign grant   = any_req & (addr_bad | mem_gnt_i);
  assign m_gnt_o = grant ? sel_oh : '0;

  always_comb begin
    last_grant_d   = last_grant_q;
    owner_d        = owner_q;
    rsp_data_d     = rsp_data_q;
    pending_d      = 1'b0;
    protocol_err_d = protocol_err_q | (mem_rvalid_i & ~pending_q & ~post_rst_q);
    if (grant) begin
      last_grant_d = sel_idx;
      owner_d      = sel_idx;
      pending_d    = ~addr_bad;
      if (addr_bad)    rsp_data_d = DATA_W'(ERR_RDATA);
      else if (sel_we) rsp_data_d = '0;
      else             rsp_data_d = mem_rdata_i;
    end
  end

`ifdef MEM_ARB_ADDR_CHECK_EN
  assign err_pending_d = grant & addr_bad;
  assign addr_err_o    = err_pending_q & ~rst;
  // Responses are gated by rst so an outstanding one is dropped on reset.
  assign rsp_fire      = ~rst & ((mem_rvalid_i & pending_q) | err_pending_q);
`else
  assign rsp_fire      = ~rst & mem_rvalid_i & pending_q;
`endif

  assign m_rvalid_o     = rsp_fire ? (NUM_MASTERS'(1) << owner_q) : '0;
  assign m_rdata_o      = rsp_data_q;
  assign protocol_err_o = protocol_err_q;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      last_grant_q   <= master_idx_t'(NUM_MASTERS - 1);
      owner_q        <= '0;
      pending_q      <= 1'b0;
      rsp_data_q     <= '0;
      post_rst_q     <= 1'b1;
      protocol_err_q <= 1'b0;
`ifdef MEM_ARB_ADDR_CHECK_EN
      err_pending_q  <= 1'b0;
`endif
    end else begin
      last_grant_q   <= last_grant_d;
      owner_q        <= owner_d;
      pending_q      <= pending_d;
      rsp_data_q     <= rsp_data_d;
      post_rst_q     <= 1'b0;
      protocol_err_q <= protocol_err_d;
`ifdef MEM_ARB_ADDR_CHECK_EN
      err_pending_q  <= err_pending_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter (2 masters). A small behavioural
// memory grants every request, returns rdata combinationally and rvalid one
// cycle later. Inputs change on the falling edge; outputs are sampled 1 ns
// later. Define MEM_ARB_ADDR_CHECK_EN to exercise the address-check feature.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [NM-1:0]  m_req;
  logic [NM-1:0]  m_gnt;
  logic [NM-1:0]  m_rvalid;
  logic [NM*AW-1:0] m_addr;
  logic [NM-1:0]  m_we;
  logic [NM*DW-1:0] m_wdata;
  logic [DW-1:0]  m_rdata;
  logic           mem_req, mem_gnt, mem_rvalid, mem_we;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_wdata, mem_rdata;
  logic           protocol_err;
`ifdef MEM_ARB_ADDR_CHECK_EN
  logic           addr_err;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .NUM_MASTERS (NM),
    .ADDR_W      (AW),
    .DATA_W      (DW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .m_req_i        (m_req),
    .m_gnt_o        (m_gnt),
    .m_rvalid_o     (m_rvalid),
    .m_addr_i       (m_addr),
    .m_we_i         (m_we),
    .m_wdata_i      (m_wdata),
    .m_rdata_o      (m_rdata),
    .mem_req_o      (mem_req),
    .mem_gnt_i      (mem_gnt),
    .mem_rvalid_i   (mem_rvalid),
    .mem_addr_o     (mem_addr),
    .mem_we_o       (mem_we),
    .mem_wdata_o    (mem_wdata),
    .mem_rdata_i    (mem_rdata),
`ifdef MEM_ARB_ADDR_CHECK_EN
    .addr_err_o     (addr_err),
`endif
    .protocol_err_o (protocol_err)
  );

  // Behavioural memory: 16 words, word 4 preloaded with 0x2A on reset.
  logic [31:0] mem_model [16];
  logic        mem_rv_q;
  logic        force_rv;

  assign mem_gnt    = mem_req;
  assign mem_rdata  = mem_model[mem_addr[3:0]];
  assign mem_rvalid = mem_rv_q | force_rv;

  always @(posedge clk) begin
    if (rst) begin
      mem_rv_q     <= 1'b0;
      mem_model[4] <= 32'h0000_002A;
    end else begin
      mem_rv_q <= mem_req & mem_gnt;
      if (mem_req && mem_gnt && mem_we) mem_model[mem_addr[3:0]] <= mem_wdata;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of master inputs on the falling edge, then settle.
  task automatic step(input logic [1:0] req, input logic [31:0] a0, input logic [31:0] a1,
                      input logic [1:0] we, input logic [31:0] d0, input logic [31:0] d1);
    @(negedge clk);
    m_req   = req;
    m_addr  = {a1, a0};
    m_we    = we;
    m_wdata = {d1, d0};
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; m_req = '0; m_we = '0; force_rv = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [31:0] a0, a1;
    logic [1:0]  we;
    logic [31:0] d1;
    logic [1:0]  e_gnt;
    logic [1:0]  e_rv;
    logic [31:0] e_rdata;
    logic        e_mreq;
    logic        e_mwe;
  } vec_t;

  vec_t vt [9];

  initial begin
    rst = 1'b1; m_req = '0; m_addr = '0; m_we = '0; m_wdata = '0; force_rv = 1'b0;

    //           req    a0 a1 we     d1            gnt    rv     rdata          mreq  mwe
    vt[0] = '{2'b00, 0, 0, 2'b00, 0,            2'b00, 2'b00, 32'h0,         1'b0, 1'b0};
    vt[1] = '{2'b01, 4, 0, 2'b00, 0,            2'b01, 2'b00, 32'h0,         1'b1, 1'b0};
    vt[2] = '{2'b00, 0, 0, 2'b00, 0,            2'b00, 2'b01, 32'h2A,        1'b0, 1'b0};
    vt[3] = '{2'b11, 4, 4, 2'b00, 0,            2'b10, 2'b00, 32'h2A,        1'b1, 1'b0};
    vt[4] = '{2'b11, 4, 4, 2'b00, 0,            2'b01, 2'b10, 32'h2A,        1'b1, 1'b0};
    vt[5] = '{2'b10, 0, 8, 2'b10, 32'h1234,     2'b10, 2'b01, 32'h2A,        1'b1, 1'b1};
    vt[6] = '{2'b01, 8, 0, 2'b00, 0,            2'b01, 2'b10, 32'h0,         1'b1, 1'b0};
    vt[7] = '{2'b00, 0, 0, 2'b00, 0,            2'b00, 2'b01, 32'h1234,      1'b0, 1'b0};
    vt[8] = '{2'b00, 0, 0, 2'b00, 0,            2'b00, 2'b00, 32'h1234,      1'b0, 1'b0};

    do_reset();

    // Table: reset state, single read, contention, write then read.
    for (int i = 0; i < 9; i++) begin
      step(vt[i].req, vt[i].a0, vt[i].a1, vt[i].we, 32'h0, vt[i].d1);
      check($sformatf("v%0d gnt", i),    64'(m_gnt),    64'(vt[i].e_gnt));
      check($sformatf("v%0d rvalid", i), 64'(m_rvalid), 64'(vt[i].e_rv));
      check($sformatf("v%0d rdata", i),  64'(m_rdata),  64'(vt[i].e_rdata));
      check($sformatf("v%0d mem_req", i), 64'(mem_req), 64'(vt[i].e_mreq));
      check($sformatf("v%0d mem_we", i),  64'(mem_we),  64'(vt[i].e_mwe));
      check($sformatf("v%0d perr", i), 64'(protocol_err), 64'(0));
    end

    // Contention right after reset: grants alternate starting at master 0,
    // each response lands on the master granted one cycle earlier.
    do_reset();
    for (int k = 0; k < 7; k++) begin
      logic [1:0] eg, er;
      logic [31:0] ed;
      eg = (k == 6) ? 2'b00 : ((k % 2 == 0) ? 2'b01 : 2'b10);
      er = (k == 0) ? 2'b00 : ((k % 2 == 1) ? 2'b01 : 2'b10);
      ed = (k == 0) ? 32'h0 : ((k % 2 == 1) ? 32'h2A : 32'h1234);
      step((k == 6) ? 2'b00 : 2'b11, 4, 8, 2'b00, 0, 0);
      check($sformatf("rr%0d gnt", k),    64'(m_gnt),    64'(eg));
      check($sformatf("rr%0d rvalid", k), 64'(m_rvalid), 64'(er));
      if (k > 0) check($sformatf("rr%0d rdata", k), 64'(m_rdata), 64'(ed));
    end

    // Reset in the cycle after a grant drops the response.
    step(2'b01, 4, 0, 2'b00, 0, 0);
    check("mid gnt", 64'(m_gnt), 64'(2'b01));
    @(negedge clk);
    rst = 1'b1; m_req = '0;
    #1;
    check("mid rst rvalid", 64'(m_rvalid), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    m_req = 2'b11; m_addr = {32'd8, 32'd4}; m_we = '0;
    #1;
    check("post rst gnt", 64'(m_gnt), 64'(2'b01));
    step(2'b00, 0, 0, 2'b00, 0, 0);
    check("post rst rvalid", 64'(m_rvalid), 64'(2'b01));
    check("post rst rdata", 64'(m_rdata), 64'h2A);
    check("post rst perr", 64'(protocol_err), 64'(0));

    // Spurious rvalid in the first post-reset cycle is masked.
    do_reset();
    force_rv = 1'b1;
    #1;
    check("mask rvalid", 64'(m_rvalid), 64'(0));
    step(2'b00, 0, 0, 2'b00, 0, 0);
    force_rv = 1'b0;
    #1;
    check("mask perr", 64'(protocol_err), 64'(0));
    // Later spurious rvalid sets the sticky error.
    step(2'b00, 0, 0, 2'b00, 0, 0);
    force_rv = 1'b1;
    #1;
    check("spur perr same cycle", 64'(protocol_err), 64'(0));
    check("spur rvalid", 64'(m_rvalid), 64'(0));
    step(2'b00, 0, 0, 2'b00, 0, 0);
    force_rv = 1'b0;
    #1;
    check("spur perr set", 64'(protocol_err), 64'(1));
    step(2'b01, 4, 0, 2'b00, 0, 0);
    check("spur perr hold gnt", 64'(protocol_err), 64'(1));
    step(2'b00, 0, 0, 2'b00, 0, 0);
    check("spur perr hold rsp", 64'(protocol_err), 64'(1));
    check("spur normal rvalid", 64'(m_rvalid), 64'(2'b01));
    do_reset();
    #1;
    check("perr cleared", 64'(protocol_err), 64'(0));

`ifdef MEM_ARB_ADDR_CHECK_EN
    step(2'b01, 300, 0, 2'b00, 0, 0);
    check("ac mem_req", 64'(mem_req), 64'(0));
    check("ac gnt", 64'(m_gnt), 64'(2'b01));
    check("ac addr_err early", 64'(addr_err), 64'(0));
    step(2'b00, 0, 0, 2'b00, 0, 0);
    check("ac rvalid", 64'(m_rvalid), 64'(2'b01));
    check("ac rdata", 64'(m_rdata), 64'hDEAD_BEEF);
    check("ac addr_err", 64'(addr_err), 64'(1));
    step(2'b11, 4, 4, 2'b00, 0, 0);
    check("ac rotate gnt", 64'(m_gnt), 64'(2'b10));
    check("ac addr_err clr", 64'(addr_err), 64'(0));
    check("ac perr", 64'(protocol_err), 64'(0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sits directly upstream of the single-port instruction/data memory in soc_multi.
- Merges the OBI-style req/gnt/rvalid ports of NUM_MASTERS cores (the redundant cores of the fault-tolerant cluster) onto one memory port using round-robin arbitration.
- Captures read data at grant time, because the memory's rdata is combinational on the address while its rvalid arrives one cycle later.
- Routes that data back to the owning master together with the memory's rvalid.

Parameters:
- NUM_MASTERS, 2, number of requesting ports (legal range 2..4).
- ADDR_W, 32, address width (word index, as used by the memory).
- DATA_W, 32, data width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- m_req_i  in  NUM_MASTERS  per-master request
- m_gnt_o  out  NUM_MASTERS  per-master grant
- m_rvalid_o  out  NUM_MASTERS  per-master response valid
- m_addr_i  in  NUM_MASTERS x ADDR_W  per-master address
- m_we_i  in  NUM_MASTERS  per-master write enable
- m_wdata_i  in  NUM_MASTERS x DATA_W  per-master write data
- m_rdata_o  out  DATA_W  response data, shared by all masters and qualified by m_rvalid_o
- mem_req_o  out  1  request to memory
- mem_gnt_i  in  1  memory grant (combinational from mem_req_o)
- mem_rvalid_i  in  1  memory response valid (registered grant)
- mem_addr_o  out  ADDR_W  forwarded address
- mem_we_o  out  1  forwarded write enable
- mem_wdata_o  out  DATA_W  forwarded write data
- mem_rdata_i  in  DATA_W  memory read data (combinational on mem_addr_o)
- protocol_err_o  out  1  sticky: memory rvalid with no pending response

Behaviour:
- Reset values (rst high at posedge):
  - last_grant_q = NUM_MASTERS-1, so master 0 wins first.
  - pending_q = 0, owner_q = 0, rsp_data_q = 0, protocol_err_o = 0.
  - post_rst_q = 1, masks the first cycle after reset.
  - All outputs that are combinational on state read 0 while pending_q = 0 and no request is active.
- Arbitration (combinational):
  - sel is the first requesting master scanning upward, with wrap, from last_grant_q+1.
  - mem_req_o = |m_req_i.
  - mem_addr_o, mem_we_o and mem_wdata_o are muxed from sel.
  - With no requests, sel = 0 and mem_we_o = 0.
- Grant:
  - m_gnt_o[sel] = mem_gnt_i & m_req_i[sel]; every other bit is 0.
  - Grant is in the same cycle as the request; at most one grant per cycle.
- On a grant, at the next clock edge:
  - last_grant_q <= sel, pending_q <= 1, owner_q <= sel.
  - Read: rsp_data_q <= mem_rdata_i. Write: rsp_data_q <= 0.
- With no grant, pending_q <= 0 at the next clock edge. The memory has 1-cycle latency, so at most one response is outstanding.
- Response: m_rvalid_o[owner_q] = mem_rvalid_i & pending_q; m_rdata_o = rsp_data_q.
- Throughput: back-to-back grants at 1 per cycle. A response for the grant at cycle t and a new grant at cycle t+1 coexist without stall.
- Fairness: a continuously requesting master waits at most NUM_MASTERS-1 grants.
- Masters hold req/addr/we/wdata stable until granted. The arbiter does not check this.
- protocol_err_o:
  - Set when mem_rvalid_i & !pending_q & !post_rst_q.
  - Cleared only by rst.
  - post_rst_q clears one cycle after rst deasserts; this tolerates the memory's independently timed reset.
- Reset mid-operation: any outstanding response is discarded and no m_rvalid_o is issued for it.
- Writes still produce rvalid, with rdata = 0.

Optional Feature:
- Macro MEM_ARB_ADDR_CHECK_EN.
- When defined:
  - A selected address >= MEM_DEPTH is not forwarded; mem_req_o = 0 for that cycle.
  - The arbiter grants the master itself.
  - It returns rvalid to that master the next cycle with rdata = ERR_RDATA. This path is independent of mem_rvalid_i.
  - It pulses addr_err_o (extra 1-bit output) in the response cycle.
  - last_grant_q rotates as for a normal grant.
- When undefined: the full address is forwarded unchecked and the addr_err_o port is absent.

Decomposition:
- Package mem_arb_pkg contains:
  - MEM_DEPTH = 256.
  - ERR_RDATA = 32'hDEAD_BEEF.
  - typedef master_idx_t (logic [1:0]).
- Sub-module rr_arbiter (req vector plus last-grant in, one-hot sel plus index out, purely combinational) is instantiated once.

Test Plan:
- Single read: master 0 reads addr 4 holding 0x0000_002A -> m_gnt_o = 01 in that cycle; next cycle m_rvalid_o = 01 and m_rdata_o = 0x2A.
- Contention: both masters request continuously for 6 cycles after reset -> grant order 0,1,0,1,0,1; each rvalid lands on the correct master one cycle after its grant.
- Write then read: master 1 writes 0x1234 to addr 8, then master 0 reads addr 8 -> write rvalid carries rdata 0; the read returns 0x1234.
- Reset mid-operation: assert rst in the cycle after a grant -> no m_rvalid_o that cycle; after release, the first grant goes to master 0; protocol_err_o stays 0.
- Spurious memory rvalid: force mem_rvalid_i = 1 with no prior grant (not in the first post-reset cycle) -> protocol_err_o = 1 and remains set until rst.
- With MEM_ARB_ADDR_CHECK_EN: read addr 300 -> mem_req_o = 0; next cycle rvalid with rdata 0xDEAD_BEEF and addr_err_o = 1.
